// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-word transfer engine: walks a register mask lowest-first and moves
// one word per cycle between the word memory and the register file.
module lm_sm_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                    clk,
    input  logic                    proc_rst,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [NREG-1:0]         reg_mask,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mem_wr_n,
    output logic                    mem_rd_n,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [$clog2(NREG)-1:0] rf_rd_idx,
    input  logic [DATA_W-1:0]       rf_rd_data,
    output logic                    rf_wr_en,
    output logic [$clog2(NREG)-1:0] rf_wr_idx,
    output logic [DATA_W-1:0]       rf_wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [NREG-1:0]   mask_r;
    logic [NREG-1:0]   mask_rest;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] cnt;
    logic              store_r;
    logic [IDX_W-1:0]  cur_idx;

    // Priority encoder: lowest set bit wins because the loop runs high-to-low.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign cur_idx   = lowest_set(mask_r);
    assign mask_rest = mask_r & (mask_r - NREG'(1));

    // Address wraps naturally through truncation to ADDR_W.
    assign mem_addr  = base_r + cnt;
    assign mem_wdata = rf_rd_data;
    assign rf_rd_idx = cur_idx;

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_nxt = state;
        mem_wr_n  = 1'b1;
        mem_rd_n  = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (reg_mask != '0) ? XFER : DONE;
            end
            XFER: begin
                busy = 1'b1;
                if (store_r) mem_wr_n = 1'b0;
                else         mem_rd_n = 1'b0;
                if (mask_rest == '0) state_nxt = store_r ? DONE : DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer context: latched at start so later input changes have no effect.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            mask_r  <= '0;
            base_r  <= '0;
            cnt     <= '0;
            store_r <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mask_r  <= reg_mask;
                base_r  <= base_addr;
                store_r <= is_store;
                cnt     <= '0;
            end else if (state == XFER) begin
                mask_r  <= mask_rest;
                cnt     <= cnt + ADDR_W'(1);
            end
        end
    end

    // LM write-back trails the read issue by one cycle; the final one lands in DRAIN.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_idx  <= '0;
            rf_wr_data <= '0;
        end else begin
            rf_wr_en <= (state == XFER) && !store_r;
            if (state == XFER && !store_r) begin
                rf_wr_idx  <= cur_idx;
                rf_wr_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: memory/register-file models plus
// scoreboard queues of expected memory writes and register writes.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        proc_rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [7:0]  reg_mask = '0;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr_n;
    logic        mem_rd_n;
    logic [15:0] mem_rdata;
    logic [2:0]  rf_rd_idx;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_idx;
    logic [15:0] rf_wr_data;
    logic        busy;
    logic        done;

    lm_sm_sequencer dut (
        .clk        (clk),
        .proc_rst   (proc_rst),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .reg_mask   (reg_mask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_n   (mem_wr_n),
        .mem_rd_n   (mem_rd_n),
        .mem_rdata  (mem_rdata),
        .rf_rd_idx  (rf_rd_idx),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_idx  (rf_wr_idx),
        .rf_wr_data (rf_wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Models: memory acts on negedge, register file writes on posedge.
    logic [15:0] mem [32];
    logic [15:0] rf [8];
    logic [15:0] mem_init [32];
    logic [15:0] rf_init [8];
    logic        load = 1'b0;

    assign rf_rd_data = rf[rf_rd_idx];

    always @(negedge clk) begin
        if (load) mem <= mem_init;
        else if (!mem_wr_n) mem[mem_addr] <= mem_wdata;
        if (!mem_rd_n) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (load) rf <= rf_init;
        else if (rf_wr_en) rf[rf_wr_idx] <= rf_wr_data;
    end

    // Scoreboard: {addr,data} for memory writes, {idx,data} for register writes.
    logic [20:0] exp_mem [$];
    logic [18:0] exp_rf [$];
    int wr_low = 0;
    int rd_low = 0;

    always @(negedge clk) begin
        logic [20:0] em;
        logic [18:0] er;
        if (proc_rst) begin
            if (!mem_wr_n) begin
                wr_low <= wr_low + 1;
                if (exp_mem.size() == 0) check("mem_wr_unexpected", 1, 0);
                else begin
                    em = exp_mem.pop_front();
                    check("mem_wr_addr", 32'(mem_addr), 32'(em[20:16]));
                    check("mem_wr_data", 32'(mem_wdata), 32'(em[15:0]));
                end
            end
            if (!mem_rd_n) begin
                rd_low <= rd_low + 1;
                check("rd_while_wr", 32'(mem_wr_n), 1);
            end
            if (rf_wr_en) begin
                if (exp_rf.size() == 0) check("rf_wr_unexpected", 1, 0);
                else begin
                    er = exp_rf.pop_front();
                    check("rf_wr_idx", 32'(rf_wr_idx), 32'(er[18:16]));
                    check("rf_wr_data", 32'(rf_wr_data), 32'(er[15:0]));
                end
            end
        end
    end

    task automatic preload();
        @(negedge clk);
        #1 load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 load = 1'b0;
    endtask

    task automatic run(input logic st, input logic [4:0] base, input logic [7:0] mask,
                       input bit inject);
        int n, cyc, wr0, rd0, exp_lat;
        logic [4:0] a;
        preload();
        n = 0;
        for (int j = 0; j < 8; j++) begin
            if (mask[j]) begin
                a = base + 5'(n);
                if (st) exp_mem.push_back({a, rf_init[j]});
                else    exp_rf.push_back({3'(j), mem_init[a]});
                n++;
            end
        end
        exp_lat = (mask == 8'h00) ? 1 : (st ? n + 1 : n + 2);
        wr0 = wr_low;
        rd0 = rd_low;
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; reg_mask = mask;
        @(posedge clk);
        #1 start = 1'b0; is_store = ~st; base_addr = 5'($urandom); reg_mask = 8'($urandom);
        cyc = 1;
        @(negedge clk);
        if (mask != 8'h00) check("busy_first", 32'(busy), 1);
        while (!done && cyc < 40) begin
            if (inject) begin
                start = (cyc == 1);
                reg_mask = 8'($urandom);
                base_addr = 5'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", 32'(cyc), 32'(exp_lat));
        check("busy_at_done", 32'(busy), 0);
        @(negedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("wr_low_cycles", 32'(wr_low - wr0), st ? 32'(n) : 32'd0);
        check("rd_low_cycles", 32'(rd_low - rd0), st ? 32'd0 : 32'(n));
        check("mem_queue_empty", 32'(exp_mem.size()), 0);
        check("rf_queue_empty", 32'(exp_rf.size()), 0);
    endtask

    initial begin
        int wr0;
        for (int i = 0; i < 32; i++) mem_init[i] = 16'h1000 + 16'(i);
        mem_init[2] = 16'd1;
        mem_init[3] = 16'd2;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'd100 + 16'(i);

        // Reset state
        #3;
        check("rst_mem_wr_n", 32'(mem_wr_n), 1);
        check("rst_mem_rd_n", 32'(mem_rd_n), 1);
        check("rst_rf_wr_en", 32'(rf_wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_rf_rd_idx", 32'(rf_rd_idx), 0);
        check("rst_rf_wr_idx", 32'(rf_wr_idx), 0);
        check("rst_rf_wr_data", 32'(rf_wr_data), 0);
        @(negedge clk);
        proc_rst = 1'b1;

        run(1'b0, 5'd2,  8'b0000_0101, 1'b0);   // LM two words
        run(1'b1, 5'd10, 8'hFF,        1'b0);   // SM eight words
        run(1'b0, 5'd30, 8'b0000_1110, 1'b0);   // LM with address wrap
        run(1'b0, 5'd7,  8'h00,        1'b0);   // empty mask
        run(1'b1, 5'd31, 8'b1000_0001, 1'b0);   // SM with wrap, sparse mask
        run(1'b0, 5'd5,  8'b1011_0010, 1'b1);   // LM with start re-asserted mid-transfer

        // Reset during the third word of an eight-word SM
        preload();
        wr0 = wr_low;
        exp_mem.push_back({5'd20, rf_init[0]});
        exp_mem.push_back({5'd21, rf_init[1]});
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; base_addr = 5'd20; reg_mask = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 proc_rst = 1'b0;
        #1;
        check("rst_mid_wr_n", 32'(mem_wr_n), 1);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(done), 0);
        @(negedge clk);
        #1;
        proc_rst = 1'b1;
        check("rst_mid_words", 32'(wr_low - wr0), 2);
        check("rst_mid_mem20", 32'(mem[20]), 32'(rf_init[0]));
        check("rst_mid_mem22", 32'(mem[22]), 32'(mem_init[22]));
        check("rst_mid_queue", 32'(exp_mem.size()), 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_idle_busy", 32'(busy), 0);
        check("rst_mid_idle_wr_n", 32'(mem_wr_n), 1);

        run(1'b1, 5'd0, 8'b0110_0000, 1'b0);    // normal operation after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
